// File: rtl/mix_column_fwd_seq.sv
// Sequential forward AES MixColumns: one 32-bit column per cycle,
// IDLE/BUSY/DONE handshake FSM with a held output register.
module mix_column_fwd_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] din,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] dout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state;
    logic [1:0]   cnt;
    logic [127:0] st_reg;
    logic [127:0] res_reg;
    logic [31:0]  col_in;
    logic [31:0]  col_out;
    logic [127:0] res_next;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Column 0 is the most significant word; only the current slice is replaced.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        col_in   = 32'h0;
        res_next = res_reg;
        unique case (cnt)
            2'd0: col_in = st_reg[127:96];
            2'd1: col_in = st_reg[95:64];
            2'd2: col_in = st_reg[63:32];
            2'd3: col_in = st_reg[31:0];
        endcase
        col_out = mix_col(col_in);
        unique case (cnt)
            2'd0: res_next[127:96] = col_out;
            2'd1: res_next[95:64]  = col_out;
            2'd2: res_next[63:32]  = col_out;
            2'd3: res_next[31:0]   = col_out;
        endcase
    end

    // dout is a separate register so it keeps the previous result while a
    // new state is being built up in res_reg.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            st_reg    <= 128'h0;
            res_reg   <= 128'h0;
            dout      <= 128'h0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        st_reg   <= din;
                        cnt      <= 2'd0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    res_reg <= res_next;
                    cnt     <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        dout      <= res_next;
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mix_column_fwd_seq.md
MIX_COLUMN_FWD_SEQ -- requirements
Module: mix_column_fwd_seq

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 128 bits and the column width at 32 bits.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset: clk input 1 (rising edge, sole clock).
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 din  input  128  AES state to transform; column c = din[127-32c -: 32], byte r of column c = din[127-32c-8r -: 8].
REQ-005 in_valid  input  1  din is valid.
REQ-006 in_ready  output  1  the block can accept a state.
REQ-007 dout  output  128  forward MixColumns result, with the same byte mapping as din.
REQ-008 out_valid  output  1  dout holds a complete result.
REQ-009 out_ready  input  1  the consumer accepts dout.
REQ-010 busy  output  1  high while a computation is in progress (BUSY state).

Function
REQ-011 The block SHALL compute the forward AES MixColumns transform, one column per cycle.
REQ-012 Per column (a0..a3 -> b0..b3), in GF(2^8):
- b0 = 2a0^3a1^a2^a3
- b1 = a0^2a1^3a2^a3
- b2 = a0^a1^2a2^3a3
- b3 = 3a0^a1^a2^2a3
REQ-013 The GF(2^8) operations SHALL be defined as follows:
- xtime(x) = {x[6:0],0} ^ (8'h1b if x[7]).
- 3x = xtime(x)^x.
- All results are 8-bit with no carries.
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-015 IDLE: in_ready=1, busy=0, out_valid=0. On in_valid=1 the block SHALL:
- capture din into an internal 128-bit state register;
- clear the 2-bit column counter;
- go to BUSY.
REQ-016 BUSY: in_ready=0, busy=1. Each cycle the block SHALL write the result for column[counter] into the matching 32-bit slice of the result register and increment the counter.
REQ-017 When BUSY processes column 3, the block SHALL go to DONE; the counter wraps to 0 and is not used in DONE.
REQ-018 DONE: out_valid=1, busy=0, in_ready=0. dout SHALL hold stable until out_ready=1 is sampled.
REQ-019 On out_ready=1 in DONE, the block SHALL go to IDLE, with out_valid=0 from the next cycle.
REQ-020 Throughput SHALL be one state per 6 cycles minimum; accept and emit never overlap.
REQ-021 Latency: if din is accepted at rising edge N, out_valid SHALL be 1 after edge N+4, and dout SHALL be complete at that point.
REQ-022 in_valid SHALL be ignored outside IDLE; changes to din after acceptance SHALL not affect the result.
REQ-023 out_ready SHALL be ignored outside DONE.
REQ-024 dout SHALL retain the last result after handshake, through IDLE and BUSY, until the next DONE completes all four slices.
REQ-025 In BUSY, only the slice for the current column SHALL change; the other slices hold.
REQ-026 in_valid=1 in IDLE in the same cycle as a stale out_ready=1 SHALL be handled as a normal accept.

Reset
REQ-027 While rst=1 the block SHALL asynchronously force:
- state=IDLE;
- column counter=0;
- state and result registers=128'h0;
- dout=0, out_valid=0, busy=0.
in_ready SHALL be 1 while rst is high.
REQ-028 Reset asserted in BUSY or DONE SHALL abort the computation; no partial result is ever signalled with out_valid.
REQ-029 After rst deasserts, the first rising edge with in_valid=1 SHALL accept.

Verification
REQ-030 FIPS-197 vector: din=db135345_f20a225c_01010101_c6c6c6c6, in_valid pulse, out_ready=1 -> out_valid high 4 edges after accept, dout=8e4da1bc_9fdc589d_01010101_c6c6c6c6.
REQ-031 Column vector: din=d4d4d4d5_2d26314c_00000000_80808080 -> dout=d5d5d7d6_4d7ebdf8_00000000_80808080 (exercises the xtime reduction).
REQ-032 Back-pressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and din -> dout and out_valid stable, in_ready=0, no new accept; then out_ready=1 -> IDLE next cycle.
REQ-033 Reset mid-operation: assert rst 2 cycles after accept -> immediately dout=0, out_valid=0, busy=0; then a fresh vector completes correctly.
REQ-034 Back-to-back stream: 100 random states, each fed in_valid as soon as in_ready=1 -> every result matches a reference model, no drops or duplicates, 6-cycle spacing with out_ready tied to 1.
